fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_pkg.sv | 11 +
 rtl/fifo_rd_stream.sv | 118 +++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FWFT FIFO read-burst streamer.
// Holds the FSM state encoding used by fifo_rd_stream.
package fifo_rd_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_rd_stream.sv
// Reads a burst of burst_len words from a first-word-fall-through FIFO and
// presents them on a single-stage valid/ready output register.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, burst_len  one-cycle burst request and its word count (IDLE only)
//   fifo_empty        FWFT FIFO empty flag
//   fifo_dout         FWFT head word, valid while fifo_empty is low
//   fifo_pop          pop strobe to the FIFO (combinational)
//   out_valid/ready   output handshake; out_data/out_last are the payload
//   busy              burst in progress (RUN or FLUSH)
//   done              one-cycle pulse after the final word is accepted
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned WIDTH    = 128,
  parameter int unsigned LEN_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_BITS-1:0] burst_len,
  input  logic                fifo_empty,
  input  logic [WIDTH-1:0]    fifo_dout,
  output logic                fifo_pop,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  state_e              state_q, state_d;
  logic [LEN_BITS-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                pop_c;
  logic                xfer_c;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Next-state, datapath and pop decision
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;

    xfer_c = valid_q && out_ready;
    // Pop only when the output register is free or draining this cycle.
    pop_c  = (state_q == ST_RUN) && !fifo_empty && (rem_q != '0) &&
             (!valid_q || out_ready);

    if (xfer_c) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    // A same-cycle pop overrides the drain and refills the register.
    if (pop_c) begin
      data_d  = fifo_dout;
      valid_d = 1'b1;
      last_d  = (rem_q == LEN_BITS'(1));
      rem_d   = rem_q - LEN_BITS'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start && (burst_len != '0)) begin
          rem_d   = burst_len;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pop_c && (rem_q == LEN_BITS'(1))) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Only the final word can be held in the register here.
        if (xfer_c && last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_pop  = pop_c;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
